urv_trap_ctrl: RTL and testbench

Machine-mode trap controller for the uRV core. It owns the trap CSRs (mstatus, mie, mip, mtvec, mepc, mcause) that the CSR datapath reads, and decides when a synchronous exception or a pending interrupt is taken. On a trap it updates those CSRs atomically, issues a one-cycle PC redirect, then blocks new traps for a fixed pipeline-refill window. It sits beside the execute stage and the CSR unit, and consumes the CSR unit's computed write value.

---
 rtl/urv_trap_ctrl_pkg.sv | 27 ++
 rtl/urv_sync_2ff.sv | 21 ++
 rtl/urv_trap_ctrl.sv | 160 ++++++++++++++++
 tb/tb_urv_trap_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/urv_trap_ctrl_pkg.sv
// Shared definitions for the uRV trap controller: CSR selectors, trap cause codes,
// mstatus bit positions and the trap FSM state encoding.
package urv_trap_ctrl_pkg;

   localparam logic [11:0] CSR_ID_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_ID_MIE      = 12'h304;
   localparam logic [11:0] CSR_ID_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_ID_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_ID_MEPC     = 12'h341;
   localparam logic [11:0] CSR_ID_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_ID_MIP      = 12'h344;

   localparam logic [3:0] CAUSE_IRQ_EXT   = 4'd11;
   localparam logic [3:0] CAUSE_IRQ_TIMER = 4'd7;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MIE_MEIE     = 11;
   localparam int MIE_MTIE     = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRAP  = 2'd1,
      ST_FLUSH = 2'd2
   } trap_state_t;

endpackage

// File: rtl/urv_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module urv_sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/urv_trap_ctrl.sv
// Machine-mode trap controller: owns the trap CSRs, takes exceptions/interrupts and
// blocks new traps during pipeline refill. Define URV_IRQ_SYNC_EN to synchronize irq_i.
//
// state | meaning
// IDLE  | accepting traps, CSR writes and mret on qualified cycles
// TRAP  | redirect cycle, x_redirect_o high, inputs ignored
// FLUSH | refill window, counter runs down from FLUSH_CYCLES, inputs ignored
module urv_trap_ctrl
   import urv_trap_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter logic [31:0] MTVEC_RESET  = 32'h0000_0008
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        x_stall_i,
   input  logic        x_kill_i,
   input  logic        x_valid_i,
   input  logic [31:0] x_pc_i,
   input  logic        x_is_csr_i,
   input  logic [11:0] x_csr_sel_i,
   input  logic [31:0] x_csr_write_value_i,
   input  logic        x_exception_i,
   input  logic [3:0]  x_exception_cause_i,
   input  logic        x_is_mret_i,
   input  logic        irq_i,
   input  logic        irq_timer_i,
   output logic [31:0] csr_mstatus_o,
   output logic [31:0] csr_mip_o,
   output logic [31:0] csr_mie_o,
   output logic [31:0] csr_mtvec_o,
   output logic [31:0] csr_mepc_o,
   output logic [31:0] csr_mcause_o,
   output logic        x_redirect_o,
   output logic [31:0] x_redirect_pc_o
);

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

   trap_state_t state;
   logic [3:0]  flush_cnt;
   logic        st_mie, st_mpie, ie_meie, ie_mtie;
   logic [29:0] mtvec, mepc;
   logic        mcause_int;
   logic [3:0]  mcause_code;
   logic        irq_s;
   logic        qual, trap_take, trap_int;
   logic [3:0]  trap_code;
   logic        pc_unused;

`ifdef URV_IRQ_SYNC_EN
   urv_sync_2ff u_irq_sync (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .d     (irq_i),
      .q     (irq_s)
   );
`else
   assign irq_s = irq_i;
`endif

   // PC is word aligned; the low bits are never stored.
   assign pc_unused = ^x_pc_i[1:0];

   assign qual = (state == ST_IDLE) && !x_stall_i && !x_kill_i && x_valid_i;

   always_comb begin
      trap_take = 1'b0;
      trap_int  = 1'b0;
      trap_code = x_exception_cause_i;
      if (qual) begin
         if (x_exception_i) begin
            trap_take = 1'b1;
         end else if (st_mie && irq_s && ie_meie) begin
            trap_take = 1'b1;
            trap_int  = 1'b1;
            trap_code = CAUSE_IRQ_EXT;
         end else if (st_mie && irq_timer_i && ie_mtie) begin
            trap_take = 1'b1;
            trap_int  = 1'b1;
            trap_code = CAUSE_IRQ_TIMER;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state           <= ST_IDLE;
         flush_cnt       <= 4'd0;
         st_mie          <= 1'b0;
         st_mpie         <= 1'b0;
         ie_meie         <= 1'b0;
         ie_mtie         <= 1'b0;
         mtvec           <= MTVEC_RESET[31:2];
         mepc            <= 30'd0;
         mcause_int      <= 1'b0;
         mcause_code     <= 4'd0;
         x_redirect_o    <= 1'b0;
         x_redirect_pc_o <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (trap_take) begin
                  state           <= ST_TRAP;
                  mepc            <= x_pc_i[31:2];
                  st_mpie         <= st_mie;
                  st_mie          <= 1'b0;
                  mcause_int      <= trap_int;
                  mcause_code     <= trap_code;
                  x_redirect_o    <= 1'b1;
                  x_redirect_pc_o <= {mtvec, 2'b00};
               end else if (qual && x_is_mret_i) begin
                  st_mie  <= st_mpie;
                  st_mpie <= 1'b1;
               end else if (qual && x_is_csr_i) begin
                  case (x_csr_sel_i)
                     CSR_ID_MSTATUS: begin
                        st_mie  <= x_csr_write_value_i[MSTATUS_MIE];
                        st_mpie <= x_csr_write_value_i[MSTATUS_MPIE];
                     end
                     CSR_ID_MIE: begin
                        ie_meie <= x_csr_write_value_i[MIE_MEIE];
                        ie_mtie <= x_csr_write_value_i[MIE_MTIE];
                     end
                     CSR_ID_MTVEC: mtvec <= x_csr_write_value_i[31:2];
                     CSR_ID_MEPC:  mepc  <= x_csr_write_value_i[31:2];
                     CSR_ID_MCAUSE: begin
                        mcause_int  <= x_csr_write_value_i[31];
                        mcause_code <= x_csr_write_value_i[3:0];
                     end
                     default: ;
                  endcase
               end
            end
            ST_TRAP: begin
               x_redirect_o <= 1'b0;
               flush_cnt    <= FLUSH_LOAD;
               state        <= ST_FLUSH;
            end
            ST_FLUSH: begin
               if (flush_cnt <= 4'd1) begin
                  flush_cnt <= 4'd0;
                  state     <= ST_IDLE;
               end else begin
                  flush_cnt <= flush_cnt - 4'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign csr_mstatus_o = {24'd0, st_mpie, 3'd0, st_mie, 3'd0};
   assign csr_mie_o     = {20'd0, ie_meie, 3'd0, ie_mtie, 7'd0};
   assign csr_mip_o     = {20'd0, irq_s, 3'd0, irq_timer_i, 7'd0};
   assign csr_mtvec_o   = {mtvec, 2'b00};
   assign csr_mepc_o    = {mepc, 2'b00};
   assign csr_mcause_o  = {mcause_int, 27'd0, mcause_code};

endmodule

// File: tb/tb_urv_trap_ctrl.sv
// Self-checking bench for urv_trap_ctrl: directed scenarios plus a randomized run
// against a cycle-level reference model of the trap rules.
module tb_urv_trap_ctrl;

   localparam int FLUSH_CYCLES = 2;
   localparam logic [11:0] ID_MSTATUS = 12'h300;
   localparam logic [11:0] ID_MIE     = 12'h304;
   localparam logic [11:0] ID_MTVEC   = 12'h305;
   localparam logic [11:0] ID_MEPC    = 12'h341;
   localparam logic [11:0] ID_MCAUSE  = 12'h342;
   localparam logic [11:0] ID_MIP     = 12'h344;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, kill, valid, is_csr, exc, mret, irq, irq_timer;
   logic [31:0] pc, wval;
   logic [11:0] sel;
   logic [3:0]  cause;
   logic [31:0] mstatus, mip, mie, mtvec, mepc, mcause, rpc;
   logic        redirect;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [31:0] m_status, m_ie, m_tvec, m_epc, m_cause, m_rpc;
   logic        m_redirect;
   int          m_busy;
   logic        m_q1, m_q2;

   always #5 clk = ~clk;

   urv_trap_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .MTVEC_RESET(32'h0000_0008)) dut (
      .clk_i               (clk),
      .rst_n_i             (rst_n),
      .x_stall_i           (stall),
      .x_kill_i            (kill),
      .x_valid_i           (valid),
      .x_pc_i              (pc),
      .x_is_csr_i          (is_csr),
      .x_csr_sel_i         (sel),
      .x_csr_write_value_i (wval),
      .x_exception_i       (exc),
      .x_exception_cause_i (cause),
      .x_is_mret_i         (mret),
      .irq_i               (irq),
      .irq_timer_i         (irq_timer),
      .csr_mstatus_o       (mstatus),
      .csr_mip_o           (mip),
      .csr_mie_o           (mie),
      .csr_mtvec_o         (mtvec),
      .csr_mepc_o          (mepc),
      .csr_mcause_o        (mcause),
      .x_redirect_o        (redirect),
      .x_redirect_pc_o     (rpc)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stall = 0; kill = 0; valid = 0; is_csr = 0; exc = 0; mret = 0;
      irq = 0; irq_timer = 0; pc = 0; wval = 0; sel = 0; cause = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
   endtask

   task automatic csr_write(input logic [11:0] s, input logic [31:0] v);
      valid = 1; is_csr = 1; sel = s; wval = v;
      tick();
      valid = 0; is_csr = 0;
   endtask

   task automatic model_reset();
      m_status = 0; m_ie = 0; m_tvec = 32'h8; m_epc = 0; m_cause = 0;
      m_rpc = 0; m_redirect = 0; m_busy = 0; m_q1 = 0; m_q2 = 0;
   endtask

   // Advances the model by one clock using the inputs currently driven.
   task automatic model_step();
      logic        irq_vis, take;
      logic [31:0] tcause;
`ifdef URV_IRQ_SYNC_EN
      irq_vis = m_q2;
      m_q2 = m_q1;
      m_q1 = irq;
`else
      irq_vis = irq;
`endif
      m_redirect = 0;
      take = 0;
      tcause = 0;
      if (m_busy > 0) begin
         m_busy = m_busy - 1;
      end else if (valid && !stall && !kill) begin
         if (exc) begin
            take = 1; tcause = {28'd0, cause};
         end else if (m_status[3] && irq_vis && m_ie[11]) begin
            take = 1; tcause = 32'h8000_000B;
         end else if (m_status[3] && irq_timer && m_ie[7]) begin
            take = 1; tcause = 32'h8000_0007;
         end
         if (take) begin
            m_epc = pc & ~32'd3;
            m_status = (m_status[3] ? 32'h80 : 32'h0);
            m_cause = tcause;
            m_rpc = m_tvec;
            m_redirect = 1;
            m_busy = FLUSH_CYCLES + 1;
         end else if (mret) begin
            m_status = 32'h80 | (m_status[7] ? 32'h8 : 32'h0);
         end else if (is_csr) begin
            if (sel == ID_MSTATUS) m_status = wval & 32'h88;
            else if (sel == ID_MIE) m_ie = wval & 32'h880;
            else if (sel == ID_MTVEC) m_tvec = wval & ~32'd3;
            else if (sel == ID_MEPC) m_epc = wval & ~32'd3;
            else if (sel == ID_MCAUSE) m_cause = wval & 32'h8000_000F;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (mstatus !== 32'h0) begin errors++; $display("FAIL reset_mstatus got=%h exp=0", mstatus); end
      checks++; if (mie !== 32'h0) begin errors++; $display("FAIL reset_mie got=%h exp=0", mie); end
      checks++; if (mip !== 32'h0) begin errors++; $display("FAIL reset_mip got=%h exp=0", mip); end
      checks++; if (mtvec !== 32'h8) begin errors++; $display("FAIL reset_mtvec got=%h exp=8", mtvec); end
      checks++; if (mepc !== 32'h0) begin errors++; $display("FAIL reset_mepc got=%h exp=0", mepc); end
      checks++; if (mcause !== 32'h0) begin errors++; $display("FAIL reset_mcause got=%h exp=0", mcause); end
      checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got=%b exp=0", redirect); end
      checks++; if (rpc !== 32'h0) begin errors++; $display("FAIL reset_rpc got=%h exp=0", rpc); end
   endtask

   task automatic test_exception();
      int redirects;
      do_reset();
      csr_write(ID_MTVEC, 32'h0000_1003);
      checks++; if (mtvec !== 32'h1000) begin errors++; $display("FAIL exc_mtvec_wr got=%h exp=1000", mtvec); end
      csr_write(ID_MSTATUS, 32'h0000_0008);
      valid = 1; exc = 1; cause = 4'd2; pc = 32'h100;
      tick();
      clear_inputs();
      checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL exc_redirect got=%b exp=1", redirect); end
      checks++; if (rpc !== 32'h1000) begin errors++; $display("FAIL exc_rpc got=%h exp=1000", rpc); end
      checks++; if (mepc !== 32'h100) begin errors++; $display("FAIL exc_mepc got=%h exp=100", mepc); end
      checks++; if (mcause !== 32'h2) begin errors++; $display("FAIL exc_mcause got=%h exp=2", mcause); end
      checks++; if (mstatus !== 32'h80) begin errors++; $display("FAIL exc_mstatus got=%h exp=80", mstatus); end
      redirects = 0;
      for (int i = 0; i < FLUSH_CYCLES + 2; i++) begin
         tick();
         if (redirect) redirects++;
      end
      checks++; if (redirects != 0) begin errors++; $display("FAIL exc_redirect_width extra=%0d exp=0", redirects); end
   endtask

   task automatic test_irq_lockout();
      do_reset();
      csr_write(ID_MSTATUS, 32'h8);
      csr_write(ID_MIE, 32'h880);
      irq = 1; irq_timer = 1;
      repeat (3) tick();
      checks++; if (mip !== 32'h880) begin errors++; $display("FAIL irq_mip got=%h exp=880", mip); end
      valid = 1; pc = 32'h200;
      tick();
      checks++; if (mcause !== 32'h8000_000B) begin errors++; $display("FAIL irq_mcause got=%h exp=8000000b", mcause); end
      checks++; if (mepc !== 32'h200) begin errors++; $display("FAIL irq_mepc got=%h exp=200", mepc); end
      checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL irq_redirect got=%b exp=1", redirect); end
      exc = 1; cause = 4'd5; pc = 32'h300;
      for (int i = 0; i < FLUSH_CYCLES + 1; i++) begin
         tick();
         checks++;
         if (redirect !== 1'b0 || mcause !== 32'h8000_000B) begin
            errors++;
            $display("FAIL lockout_c%0d redirect=%b mcause=%h exp redirect=0 mcause=8000000b", i, redirect, mcause);
         end
      end
      tick();
      checks++;
      if (redirect !== 1'b1 || mcause !== 32'h5) begin
         errors++;
         $display("FAIL lockout_end redirect=%b mcause=%h exp redirect=1 mcause=5", redirect, mcause);
      end
      clear_inputs();
   endtask

   task automatic test_exc_priority();
      do_reset();
      csr_write(ID_MSTATUS, 32'h8);
      csr_write(ID_MIE, 32'h880);
      irq = 1; irq_timer = 1;
      repeat (3) tick();
      valid = 1; exc = 1; cause = 4'd3; pc = 32'h307;
      is_csr = 1; sel = ID_MEPC; wval = 32'h0000_ABC0;
      tick();
      clear_inputs();
      checks++; if (mcause !== 32'h3) begin errors++; $display("FAIL prio_mcause got=%h exp=3", mcause); end
      checks++; if (mepc !== 32'h304) begin errors++; $display("FAIL prio_mepc got=%h exp=304", mepc); end
   endtask

   task automatic test_mret();
      do_reset();
      csr_write(ID_MSTATUS, 32'h80);
      valid = 1; mret = 1; stall = 1;
      tick();
      checks++; if (mstatus !== 32'h80) begin errors++; $display("FAIL mret_stall got=%h exp=80", mstatus); end
      stall = 0;
      tick();
      clear_inputs();
      checks++; if (mstatus !== 32'h88) begin errors++; $display("FAIL mret_mstatus got=%h exp=88", mstatus); end
      checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL mret_redirect got=%b exp=0", redirect); end
   endtask

   task automatic test_reset_mid_trap();
      for (int k = 0; k < 2; k++) begin
         do_reset();
         csr_write(ID_MSTATUS, 32'h8);
         csr_write(ID_MTVEC, 32'h400);
         valid = 1; exc = 1; cause = 4'd4; pc = 32'h500;
         tick();
         clear_inputs();
         if (k == 1) tick();
         rst_n = 0;
         #1;
         checks++;
         if (redirect !== 1'b0 || mstatus !== 32'h0 || mtvec !== 32'h8 || mepc !== 32'h0 || mcause !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_k%0d redirect=%b mstatus=%h mtvec=%h mepc=%h mcause=%h exp 0/0/8/0/0",
                     k, redirect, mstatus, mtvec, mepc, mcause);
         end
         #2;
         rst_n = 1;
         valid = 1; exc = 1; cause = 4'd6; pc = 32'h40;
         tick();
         clear_inputs();
         checks++;
         if (redirect !== 1'b1 || mepc !== 32'h40 || rpc !== 32'h8 || mcause !== 32'h6) begin
            errors++;
            $display("FAIL rst_after_k%0d redirect=%b mepc=%h rpc=%h mcause=%h exp 1/40/8/6", k, redirect, mepc, rpc, mcause);
         end
      end
   endtask

   task automatic test_random();
      logic [11:0] sels [7];
      logic [31:0] exp_mip;
      sels = '{ID_MSTATUS, ID_MIE, ID_MTVEC, ID_MEPC, ID_MCAUSE, ID_MIP, 12'h7C0};
      do_reset();
      model_reset();
      for (int c = 0; c < 600; c++) begin
         valid     = ($urandom_range(0, 3) != 0);
         stall     = ($urandom_range(0, 4) == 0);
         kill      = ($urandom_range(0, 9) == 0);
         exc       = ($urandom_range(0, 6) == 0);
         cause     = 4'($urandom);
         pc        = $urandom;
         mret      = ($urandom_range(0, 9) == 0);
         is_csr    = !mret && ($urandom_range(0, 4) < 2);
         sel       = sels[$urandom_range(0, 6)];
         wval      = $urandom;
         irq       = ($urandom_range(0, 3) == 0);
         irq_timer = ($urandom_range(0, 3) == 0);
         model_step();
         tick();
`ifdef URV_IRQ_SYNC_EN
         exp_mip = {20'd0, m_q2, 3'd0, irq_timer, 7'd0};
`else
         exp_mip = {20'd0, irq, 3'd0, irq_timer, 7'd0};
`endif
         checks++; if (redirect !== m_redirect) begin errors++; $display("FAIL rnd_redirect c=%0d got=%b exp=%b", c, redirect, m_redirect); end
         checks++; if (rpc !== m_rpc) begin errors++; $display("FAIL rnd_rpc c=%0d got=%h exp=%h", c, rpc, m_rpc); end
         checks++; if (mstatus !== m_status) begin errors++; $display("FAIL rnd_mstatus c=%0d got=%h exp=%h", c, mstatus, m_status); end
         checks++; if (mie !== m_ie) begin errors++; $display("FAIL rnd_mie c=%0d got=%h exp=%h", c, mie, m_ie); end
         checks++; if (mtvec !== m_tvec) begin errors++; $display("FAIL rnd_mtvec c=%0d got=%h exp=%h", c, mtvec, m_tvec); end
         checks++; if (mepc !== m_epc) begin errors++; $display("FAIL rnd_mepc c=%0d got=%h exp=%h", c, mepc, m_epc); end
         checks++; if (mcause !== m_cause) begin errors++; $display("FAIL rnd_mcause c=%0d got=%h exp=%h", c, mcause, m_cause); end
         checks++; if (mip !== exp_mip) begin errors++; $display("FAIL rnd_mip c=%0d got=%h exp=%h", c, mip, exp_mip); end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst_n = 0;
      test_reset();
      test_exception();
      test_irq_lockout();
      test_exc_priority();
      test_mret();
      test_reset_mid_trap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
